// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encoding and width defaults for the ADC capture trigger controller
package adc_capture_pkg;
  localparam int OFFSET_WIDTH_DEF  = 32;
  localparam int TRIGLEN_WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    OFFSET  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;
endpackage

// File: rtl/adc_capture_ctrl_trig_conditioner.sv
// trig_conditioner: registers the trigger, corrects polarity and selects edge/level firing
// Ports: adc_sampleclk/reset_n clock and async active-low reset; trig_in_i raw synchronous trigger;
//   trig_level_i polarity (1 = active-high); trig_edge_mode_i 1 = edge, 0 = level;
//   trigger_now_i software force; trig_act polarity-corrected level; trig_event firing condition
module trig_conditioner (
  input  logic adc_sampleclk,
  input  logic reset_n,
  input  logic trig_in_i,
  input  logic trig_level_i,
  input  logic trig_edge_mode_i,
  input  logic trigger_now_i,
  output logic trig_act,
  output logic trig_event
);
  logic trig_q, trig_act_d;
  always_ff @(posedge adc_sampleclk or negedge reset_n)
    if (!reset_n) begin
      trig_q     <= 1'b0;
      trig_act_d <= 1'b0;
    end else begin
      trig_q     <= trig_in_i;
      trig_act_d <= trig_act;
    end
  assign trig_act   = trig_q ^ ~trig_level_i;
  assign trig_event = trigger_now_i | (trig_edge_mode_i ? trig_act & ~trig_act_d : trig_act);
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arm / trigger / offset sequencer driving the ADC sample FIFO capture-go
// Ports: adc_sampleclk/reset_n clock and async active-low reset; arm_i arm level (rising edge arms);
//   trig_in_i/trig_level_i/trig_edge_mode_i trigger source, polarity, mode; trigger_now_i software trigger;
//   offset_i trigger-to-capture delay; capture_stop_i end of window from FIFO stage;
//   capture_go_o, capture_armed_o, trig_status_o, capture_done_o, trig_len_o, state_o status outputs
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int OFFSET_WIDTH  = OFFSET_WIDTH_DEF,
  parameter int TRIGLEN_WIDTH = TRIGLEN_WIDTH_DEF
) (
  input  logic                     adc_sampleclk,
  input  logic                     reset_n,
  input  logic                     arm_i,
  input  logic                     trig_in_i,
  input  logic                     trig_level_i,
  input  logic                     trig_edge_mode_i,
  input  logic                     trigger_now_i,
  input  logic [OFFSET_WIDTH-1:0]  offset_i,
  input  logic                     capture_stop_i,
  output logic                     capture_go_o,
  output logic                     capture_armed_o,
  output logic                     trig_status_o,
  output logic                     capture_done_o,
  output logic [TRIGLEN_WIDTH-1:0] trig_len_o,
  output logic [2:0]               state_o
);
  state_t state, nxt;
  logic arm_q, arm_d, arm_rise, arm_take, trig_act, trig_event, fire, len_run;
  logic [OFFSET_WIDTH-1:0] offset_lat, cnt;
  trig_conditioner u_trig (
    .adc_sampleclk    (adc_sampleclk),
    .reset_n          (reset_n),
    .trig_in_i        (trig_in_i),
    .trig_level_i     (trig_level_i),
    .trig_edge_mode_i (trig_edge_mode_i),
    .trigger_now_i    (trigger_now_i),
    .trig_act         (trig_act),
    .trig_event       (trig_event)
  );
  assign arm_rise = arm_q & ~arm_d;
  // arm edges outside IDLE are dropped so a capture in flight is never disturbed
  assign arm_take = state == IDLE && arm_rise;
  // disarm beats a coincident trigger event
  assign fire     = state == ARMED && arm_q && trig_event;
  assign state_o  = state;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = arm_rise ? ARMED : IDLE;
      ARMED:   nxt = !arm_q ? IDLE : !trig_event ? ARMED : offset_lat == '0 ? CAPTURE : OFFSET;
      OFFSET:  nxt = !arm_q ? IDLE : cnt == '0 ? CAPTURE : OFFSET;
      CAPTURE: nxt = capture_stop_i ? DONE : CAPTURE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge adc_sampleclk or negedge reset_n)
    if (!reset_n) begin
      state           <= IDLE;
      arm_q           <= 1'b0;
      arm_d           <= 1'b0;
      capture_go_o    <= 1'b0;
      capture_armed_o <= 1'b0;
      capture_done_o  <= 1'b0;
      trig_status_o   <= 1'b0;
      offset_lat      <= '0;
      cnt             <= '0;
      trig_len_o      <= '0;
      len_run         <= 1'b0;
    end else begin
      arm_q           <= arm_i;
      arm_d           <= arm_q;
      state           <= nxt;
      capture_go_o    <= nxt == CAPTURE;
      capture_armed_o <= nxt == ARMED;
      capture_done_o  <= nxt == DONE;
      trig_status_o   <= trig_act;
      if (arm_take) offset_lat <= offset_i;
      // loaded with offset-1 so the count reaching zero lands exactly offset cycles later
      if (fire) cnt <= offset_lat - OFFSET_WIDTH'(1);
      else if (state == OFFSET) cnt <= cnt - OFFSET_WIDTH'(1);
      // length run starts on the firing cycle and freezes once the trigger first drops
      if (arm_take) begin
        trig_len_o <= '0;
        len_run    <= 1'b0;
      end else if (fire) begin
        trig_len_o <= TRIGLEN_WIDTH'(trig_act);
        len_run    <= trig_act;
      end else if (len_run && trig_act) trig_len_o <= &trig_len_o ? trig_len_o : trig_len_o + TRIGLEN_WIDTH'(1);
      else len_run <= 1'b0;
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for adc_capture_ctrl (32-bit and 4-bit trig_len instances)
module tb_adc_capture_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, arm = 1'b0, trig_in = 1'b0, trig_level = 1'b1;
  logic edge_mode = 1'b1, trig_now = 1'b0, stop = 1'b0;
  logic [31:0] offset = '0;
  logic go, armed, status, done, go4, armed4, status4, done4;
  logic [31:0] tlen;
  logic [3:0] tlen4;
  logic [2:0] state, state4;
  int checks = 0, errors = 0, cyc = 0;
  int sb[$];
  always #5 clk = ~clk;
  adc_capture_ctrl dut (
    .adc_sampleclk(clk), .reset_n(reset_n), .arm_i(arm), .trig_in_i(trig_in), .trig_level_i(trig_level),
    .trig_edge_mode_i(edge_mode), .trigger_now_i(trig_now), .offset_i(offset), .capture_stop_i(stop),
    .capture_go_o(go), .capture_armed_o(armed), .trig_status_o(status), .capture_done_o(done),
    .trig_len_o(tlen), .state_o(state)
  );
  adc_capture_ctrl #(.TRIGLEN_WIDTH(4)) dut4 (
    .adc_sampleclk(clk), .reset_n(reset_n), .arm_i(arm), .trig_in_i(trig_in), .trig_level_i(trig_level),
    .trig_edge_mode_i(edge_mode), .trigger_now_i(trig_now), .offset_i(offset), .capture_stop_i(stop),
    .capture_go_o(go4), .capture_armed_o(armed4), .trig_status_o(status4), .capture_done_o(done4),
    .trig_len_o(tlen4), .state_o(state4)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_go(input int budget);
    int n = 0;
    int exp_cyc;
    while (!go && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL go_scoreboard: capture_go at cycle %0d with nothing expected", cyc);
    end else begin
      exp_cyc = sb.pop_front();
      if (go !== 1'b1 || go4 !== 1'b1 || cyc !== exp_cyc) begin
        errors++;
        $display("FAIL go_cycle: go=%0b go4=%0b at cycle %0d, need go=1 at cycle %0d", go, go4, cyc, exp_cyc);
      end
    end
  endtask
  task automatic do_arm();
    arm = 1'b1;
    ticks(2);
    checks++;
    if (state !== 3'd1 || armed !== 1'b1 || go !== 1'b0) begin
      errors++;
      $display("FAIL arm: state=%0d armed=%0b go=%0b, need state=1 armed=1 go=0", state, armed, go);
    end
  endtask
  task automatic finish_capture();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (go !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL done_cycle: go=%0b done=%0b state=%0d, need go=0 done=1 state=4", go, done, state);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state !== 3'd0 || armed !== 1'b0) begin
      errors++;
      $display("FAIL done_return: done=%0b state=%0d armed=%0b, need 0/0/0", done, state, armed);
    end
  endtask
  task automatic test_reset();
    ticks(2);
    checks++;
    if ({go, armed, status, done, tlen, state} !== '0 || {go4, armed4, status4, done4, tlen4, state4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: go=%0b armed=%0b status=%0b done=%0b len=%0d state=%0d, need all 0",
               go, armed, status, done, tlen, state);
    end
    #2 reset_n = 1'b1;
    ticks(2);
  endtask
  task automatic test_edge_trigger();
    trig_level = 1'b1; edge_mode = 1'b1; offset = 0;
    do_arm();
    trig_in = 1'b1;
    sb.push_back(cyc + 2);
    wait_go(10);
    checks++;
    if (status !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL edge_status: status=%0b state=%0d, need status=1 state=3", status, state);
    end
    finish_capture();
    trig_now = 1'b1;
    tick();
    trig_now = 1'b0;
    ticks(3);
    checks++;
    if (state !== 3'd0 || go !== 1'b0) begin
      errors++;
      $display("FAIL no_rearm: state=%0d go=%0b, need state=0 go=0 without fresh arm edge", state, go);
    end
    arm = 1'b0; trig_in = 1'b0;
    ticks(2);
  endtask
  task automatic offset_run(input int dly);
    do_arm();
    offset = 9;
    trig_in = 1'b0;
    sb.push_back(cyc + 2 + dly);
    wait_go(dly + 10);
    finish_capture();
    trig_in = 1'b1; arm = 1'b0;
    ticks(2);
  endtask
  task automatic test_offset();
    trig_level = 1'b0; edge_mode = 1'b1; trig_in = 1'b1; offset = 5;
    ticks(3);
    offset_run(5);
    offset_run(9);
    trig_in = 1'b0; trig_level = 1'b1;
    ticks(2);
  endtask
  task automatic test_level_preactive();
    bit seen = 0;
    trig_level = 1'b1; edge_mode = 1'b0; offset = 0; trig_in = 1'b1;
    ticks(2);
    do_arm();
    sb.push_back(cyc + 1);
    wait_go(5);
    finish_capture();
    arm = 1'b0;
    ticks(2);
    edge_mode = 1'b1;
    do_arm();
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= go;
    end
    checks++;
    if (seen || state !== 3'd1) begin
      errors++;
      $display("FAIL edge_preactive: go seen=%0b state=%0d, need no go and state=1", seen, state);
    end
    trig_in = 1'b0;
    ticks(2);
    trig_in = 1'b1;
    sb.push_back(cyc + 2);
    wait_go(5);
    finish_capture();
    trig_in = 1'b0; arm = 1'b0;
    ticks(2);
  endtask
  task automatic test_disarm();
    bit seen = 0;
    trig_level = 1'b1; edge_mode = 1'b1; offset = 100;
    do_arm();
    trig_in = 1'b1;
    ticks(4);
    checks++;
    if (state !== 3'd2 || armed !== 1'b0) begin
      errors++;
      $display("FAIL offset_state: state=%0d armed=%0b, need state=2 armed=0", state, armed);
    end
    arm = 1'b0;
    tick();
    for (int i = 0; i < 120; i++) begin
      tick();
      seen |= go;
    end
    checks++;
    if (seen || state !== 3'd0) begin
      errors++;
      $display("FAIL offset_abort: go seen=%0b state=%0d, need no go and state=0", seen, state);
    end
    trig_in = 1'b0; offset = 0;
    ticks(2);
    do_arm();
    arm = 1'b0;
    tick();
    trig_now = 1'b1;
    tick();
    trig_now = 1'b0;
    checks++;
    if (state !== 3'd0 || go !== 1'b0) begin
      errors++;
      $display("FAIL disarm_wins: state=%0d go=%0b, need state=0 go=0", state, go);
    end
    ticks(2);
    do_arm();
    trig_in = 1'b1;
    sb.push_back(cyc + 2);
    wait_go(5);
    arm = 1'b0;
    ticks(3);
    arm = 1'b1;
    ticks(3);
    checks++;
    if (go !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL capture_hold: go=%0b state=%0d, need go=1 state=3 despite arm toggling", go, state);
    end
    finish_capture();
    ticks(3);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL arm_ignored: state=%0d, need 0 (arm edge during capture dropped)", state);
    end
    trig_in = 1'b0; arm = 1'b0;
    ticks(2);
  endtask
  task automatic test_trig_len(input int n, input int exp4);
    int start;
    trig_level = 1'b1; edge_mode = 1'b1; offset = 0;
    do_arm();
    start = cyc;
    trig_in = 1'b1;
    sb.push_back(cyc + 2);
    wait_go(5);
    while (cyc < start + n) tick();
    trig_in = 1'b0;
    ticks(3);
    checks++;
    if (tlen !== 32'(n) || tlen4 !== 4'(exp4)) begin
      errors++;
      $display("FAIL trig_len: len=%0d len4=%0d, need %0d and %0d", tlen, tlen4, n, exp4);
    end
    finish_capture();
    arm = 1'b0;
    ticks(2);
  endtask
  task automatic test_trigger_now();
    trig_level = 1'b1; edge_mode = 1'b1; offset = 0; trig_in = 1'b0;
    do_arm();
    checks++;
    if (tlen !== '0 || tlen4 !== '0) begin
      errors++;
      $display("FAIL len_clear: len=%0d len4=%0d, need 0 after arming", tlen, tlen4);
    end
    trig_now = 1'b1;
    sb.push_back(cyc + 1);
    tick();
    trig_now = 1'b0;
    wait_go(3);
    ticks(2);
    checks++;
    if (tlen !== '0) begin
      errors++;
      $display("FAIL now_len: len=%0d, need 0", tlen);
    end
    finish_capture();
    arm = 1'b0;
    ticks(2);
  endtask
  task automatic test_reset_mid_capture();
    bit seen = 0;
    do_arm();
    trig_now = 1'b1;
    sb.push_back(cyc + 1);
    tick();
    trig_now = 1'b0;
    wait_go(3);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({go, armed, status, done, tlen, state} !== '0) begin
      errors++;
      $display("FAIL async_reset: go=%0b armed=%0b done=%0b state=%0d, need all 0", go, armed, done, state);
    end
    arm = 1'b0;
    tick();
    #3 reset_n = 1'b1;
    tick();
    trig_now = 1'b1;
    tick();
    trig_now = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= go;
    end
    checks++;
    if (seen || state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset: go seen=%0b state=%0d, need no capture and state=0", seen, state);
    end
  endtask
  initial begin
    test_reset();
    test_edge_trigger();
    test_offset();
    test_level_preactive();
    test_disarm();
    test_trig_len(37, 15);
    test_trigger_now();
    test_trig_len(40, 15);
    test_reset_mid_capture();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected captures never seen, need 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
